// File: rtl/pu_pkg.sv
// pu_pkg: shared definitions for the pu core decode path.
//   liop_e      - immediate-path select presented to the ALU stage
//   Opc*        - major opcode values found in ins[15:13]
//   Alu*        - ALU op codes
//   *Lsb / *Bit - bit positions of the fixed 16-bit instruction fields
//   opcode()    - extracts the major opcode from an instruction word
package pu_pkg;

  // Immediate-path select: pass-through, immediate operand, load low, load high.
  typedef enum logic [1:0] {
    LiThu = 2'd0,
    LiImm = 2'd1,
    LiLil = 2'd2,
    LiLih = 2'd3
  } liop_e;

  // Major opcodes in ins[15:13]; 011, 110 and 111 are undefined.
  localparam logic [2:0] OpcSys    = 3'b000;
  localparam logic [2:0] OpcCalImm = 3'b001;
  localparam logic [2:0] OpcLi     = 3'b010;
  localparam logic [2:0] OpcLmImm  = 3'b100;
  localparam logic [2:0] OpcSm     = 3'b101;

  // ALU op codes.
  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluTru = 3'd2;

  // Field positions for the 16-bit instruction word.
  localparam int unsigned OpcLsb     = 13;
  localparam int unsigned SubBit     = 12; // CAL/LM select, LIL/LIH select, SUB select
  localparam int unsigned WadLsb     = 10;
  localparam int unsigned SmBrLsb    = 10; // SM puts its data register where wad normally sits
  localparam int unsigned ArLsb      = 8;
  localparam int unsigned LiBrLsb    = 8;  // LIL/LIH read their merge source from the A slot
  localparam int unsigned CalOpLsb   = 4;
  localparam int unsigned RegFormBit = 2;  // in the 000 group: 1 = register-form ALU/load
  localparam int unsigned HaltBit    = 0;  // in the 000 group: 1 = HALT, 0 = NOP
  localparam int unsigned BrLsb      = 0;

  function automatic logic [2:0] opcode(input logic [15:0] ins);
    return ins[15:13];
  endfunction

endpackage

// File: rtl/pu_dec_comb.sv
// pu_dec_comb: purely combinational decode of one pu instruction word.
//   ins      in   instruction word
//   h        out  HALT
//   we       out  register write enable
//   wad      out  write register address
//   op       out  ALU op
//   arad     out  A read address
//   brad     out  B read address
//   liop     out  immediate-path select
//   iv       out  immediate value
//   dmwe     out  data-memory write
//   dms      out  data-memory select (load)
//   ua, ub   out  A / B read address is actually consumed (drives the load interlock)
//   illegal  out  undefined major opcode; decodes as NOP
module pu_dec_comb
  import pu_pkg::*;
#(
  parameter int unsigned CMDW  = 16,
  parameter int unsigned RAW   = 2,
  parameter int unsigned OPW   = 3,
  parameter int unsigned HALFW = 8
) (
  input  logic [CMDW-1:0]  ins,
  output logic             h,
  output logic             we,
  output logic [RAW-1:0]   wad,
  output logic [OPW-1:0]   op,
  output logic [RAW-1:0]   arad,
  output logic [RAW-1:0]   brad,
  output liop_e            liop,
  output logic [HALFW-1:0] iv,
  output logic             dmwe,
  output logic             dms,
  output logic             ua,
  output logic             ub,
  output logic             illegal
);

  logic [2:0]     opc;
  logic [RAW-1:0] f_wad;
  logic [RAW-1:0] f_ar;
  logic [RAW-1:0] f_br;
  logic [OPW-1:0] f_op_sub;

  assign opc      = opcode(ins[15:0]);
  assign f_wad    = ins[WadLsb +: RAW];
  assign f_ar     = ins[ArLsb +: RAW];
  assign f_br     = ins[BrLsb +: RAW];
  // Immediate forms only choose between ADD and SUB.
  assign f_op_sub = {{(OPW-1){1'b0}}, ins[SubBit]};

  always_comb begin
    h       = 1'b0;
    we      = 1'b0;
    wad     = '0;
    op      = '0;
    arad    = '0;
    brad    = '0;
    liop    = LiThu;
    iv      = '0;
    dmwe    = 1'b0;
    dms     = 1'b0;
    ua      = 1'b0;
    ub      = 1'b0;
    illegal = 1'b0;
    case (opc)
      OpcSys: begin
        if (ins[RegFormBit]) begin
          // CAL-reg or LM-reg share every field; only dms differs.
          we   = 1'b1;
          wad  = f_wad;
          arad = f_ar;
          brad = f_br;
          op   = ins[CalOpLsb +: OPW];
          dms  = ins[SubBit];
          ua   = 1'b1;
          ub   = 1'b1;
        end else begin
          h = ins[HaltBit];
        end
      end
      OpcCalImm: begin
        we   = 1'b1;
        wad  = f_wad;
        arad = f_ar;
        op   = f_op_sub;
        liop = LiImm;
        iv   = ins[HALFW-1:0];
        ua   = 1'b1;
      end
      OpcLi: begin
        we   = 1'b1;
        wad  = f_wad;
        brad = ins[LiBrLsb +: RAW];
        op   = OPW'(AluTru);
        liop = ins[SubBit] ? LiLih : LiLil;
        iv   = ins[HALFW-1:0];
        ub   = 1'b1;
      end
      OpcLmImm: begin
        we   = 1'b1;
        wad  = f_wad;
        dms  = 1'b1;
        arad = f_ar;
        op   = f_op_sub;
        liop = LiImm;
        iv   = ins[HALFW-1:0];
        ua   = 1'b1;
      end
      OpcSm: begin
        brad = ins[SmBrLsb +: RAW];
        arad = f_ar;
        op   = f_op_sub;
        liop = LiImm;
        iv   = ins[HALFW-1:0];
        dmwe = 1'b1;
        ua   = 1'b1;
        ub   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pu_dec_stage.sv
// pu_dec_stage: registered instruction-decode stage between fetch and the regfile/ALU stage.
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   fetch handshake; ins is consumed when both are high
//   ins                   instruction word
//   out_valid / out_ready downstream handshake for the registered decoded fields
//   h, we, wad, op, arad, brad, liop, iv, dmwe, dms   decoded control fields
//   illegal               one-cycle pulse with the first out_valid of an undefined opcode
//   halted                sticky once a HALT is accepted; cleared only by reset
// A load shadow of LD_LAT entries tracks in-flight loads so a dependent instruction is
// held back until the loaded value is available.
module pu_dec_stage
  import pu_pkg::*;
#(
  parameter int unsigned CMDW   = 16,
  parameter int unsigned RAW    = 2,
  parameter int unsigned OPW    = 3,
  parameter int unsigned HALFW  = 8,
  parameter int unsigned LD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMDW-1:0]  ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             h,
  output logic             we,
  output logic [RAW-1:0]   wad,
  output logic [OPW-1:0]   op,
  output logic [RAW-1:0]   arad,
  output logic [RAW-1:0]   brad,
  output logic [1:0]       liop,
  output logic [HALFW-1:0] iv,
  output logic             dmwe,
  output logic             dms,
  output logic             illegal,
  output logic             halted
);

  if (CMDW != 16) begin : g_bad_cmdw
    $fatal(1, "pu_dec_stage: CMDW must be 16");
  end
  if (LD_LAT < 1 || LD_LAT > 4) begin : g_bad_ld_lat
    $fatal(1, "pu_dec_stage: LD_LAT must be 1..4");
  end

  // Combinational decode of the candidate instruction.
  logic             d_h;
  logic             d_we;
  logic [RAW-1:0]   d_wad;
  logic [OPW-1:0]   d_op;
  logic [RAW-1:0]   d_arad;
  logic [RAW-1:0]   d_brad;
  liop_e            d_liop;
  logic [HALFW-1:0] d_iv;
  logic             d_dmwe;
  logic             d_dms;
  logic             d_ua;
  logic             d_ub;
  logic             d_illegal;

  pu_dec_comb #(
    .CMDW  (CMDW),
    .RAW   (RAW),
    .OPW   (OPW),
    .HALFW (HALFW)
  ) u_dec_comb (
    .ins     (ins),
    .h       (d_h),
    .we      (d_we),
    .wad     (d_wad),
    .op      (d_op),
    .arad    (d_arad),
    .brad    (d_brad),
    .liop    (d_liop),
    .iv      (d_iv),
    .dmwe    (d_dmwe),
    .dms     (d_dms),
    .ua      (d_ua),
    .ub      (d_ub),
    .illegal (d_illegal)
  );

  // Output register.
  logic             out_valid_q;
  logic             h_q;
  logic             we_q;
  logic [RAW-1:0]   wad_q;
  logic [OPW-1:0]   op_q;
  logic [RAW-1:0]   arad_q;
  logic [RAW-1:0]   brad_q;
  liop_e            liop_q;
  logic [HALFW-1:0] iv_q;
  logic             dmwe_q;
  logic             dms_q;
  logic             illegal_q;
  logic             halted_q;

  // Load shadow: entry i holds a load issued i+1 advances ago.
  logic [LD_LAT-1:0]          sh_ld_q;
  logic [LD_LAT-1:0][RAW-1:0] sh_wad_q;

  logic adv;
  logic hazard;
  logic accept;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !hazard && !halted_q && rst_n;
  assign accept   = in_valid && in_ready;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LD_LAT; i++) begin
      if (sh_ld_q[i] && ((d_ua && (d_arad == sh_wad_q[i])) ||
                         (d_ub && (d_brad == sh_wad_q[i])))) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_ld_q  <= '0;
      sh_wad_q <= '0;
    end else if (adv) begin
      sh_ld_q[0]  <= accept && d_dms;
      sh_wad_q[0] <= d_wad;
      for (int i = 1; i < LD_LAT; i++) begin
        sh_ld_q[i]  <= sh_ld_q[i-1];
        sh_wad_q[i] <= sh_wad_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      h_q         <= 1'b0;
      we_q        <= 1'b0;
      wad_q       <= '0;
      op_q        <= '0;
      arad_q      <= '0;
      brad_q      <= '0;
      liop_q      <= LiThu;
      iv_q        <= '0;
      dmwe_q      <= 1'b0;
      dms_q       <= 1'b0;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      // Pulse only on the edge that accepts the undefined word.
      illegal_q <= accept && d_illegal;
      if (accept) begin
        out_valid_q <= 1'b1;
        h_q         <= d_h;
        we_q        <= d_we;
        wad_q       <= d_wad;
        op_q        <= d_op;
        arad_q      <= d_arad;
        brad_q      <= d_brad;
        liop_q      <= d_liop;
        iv_q        <= d_iv;
        dmwe_q      <= d_dmwe;
        dms_q       <= d_dms;
        if (d_h) begin
          halted_q <= 1'b1;
        end
      end else if (adv) begin
        // Bubble: fields keep their last values.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign h         = h_q;
  assign we        = we_q;
  assign wad       = wad_q;
  assign op        = op_q;
  assign arad      = arad_q;
  assign brad      = brad_q;
  assign liop      = liop_q;
  assign iv        = iv_q;
  assign dmwe      = dmwe_q;
  assign dms       = dms_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule

// File: doc/pu_dec_stage.md
Name: pu_dec_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the pu core. Sits between instruction fetch and the register-file/ALU stage.
- Decodes the 16-bit pu ISA into control fields, presented as a registered output with a valid/ready handshake.
- Adds three things: a load-use interlock with configurable data-memory latency, sticky HALT handling, and illegal-opcode reporting.
- Fixes two encoding gaps: LM-immediate now asserts dms, and SM no longer asserts we.

Parameters:
- CMDW, 16: instruction width. The field layout below is fixed for 16 bits; other values are illegal (elaboration assertion).
- RAW, 2: register address width. rw, a and b fields occupy bits [11:10], [9:8] and [1:0].
- OPW, 3: ALU op width.
- HALFW, 8: immediate width; iv = ins[HALFW-1:0].
- LD_LAT, 1: cycles a loaded value is unavailable after LM issue (1..4). Sets the depth of the load shadow register.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts ins this cycle
- ins  in  CMDW  instruction word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream accepts
- h  out  1  halt
- we  out  1  register write enable
- wad  out  RAW  write register address
- op  out  OPW  ALU op
- arad  out  RAW  A read address
- brad  out  RAW  B read address
- liop  out  2  THU=0, IMM=1, LIL=2, LIH=3
- iv  out  HALFW  immediate
- dmwe  out  1  data-memory write
- dms  out  1  data-memory select (load)
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted
- halted  out  1  sticky halt status

Behaviour:
- Reset (rst_n=0 at posedge), all outputs zero:
  - out_valid=0, in_ready=0 during reset, halted=0, illegal=0, liop=THU.
  - Load shadow register cleared.
  - Reset mid-stall or mid-halt abandons everything; first acceptance is possible on the cycle after rst_n rises.
- Decode, on ins[15:13]:
  - 000, o[2]=0: NOP if o[0]=0, HALT if o[0]=1.
  - 000, o[2]=1: CAL-reg if o[12]=0; LM-reg (dms=1) if o[12]=1. Both: wad=[11:10], we=1, arad=[9:8], op=[6:4], brad=[1:0].
  - 001: CAL-imm. wad, we=1, arad, op={0,o[12]}, liop=IMM, iv=ins[7:0].
  - 010: LIL if o[12]=0, LIH if o[12]=1. wad, we=1, brad=[9:8], op=3'b010, liop=LIL/LIH, iv.
  - 100: LM-imm. wad, we=1, dms=1, arad, op={0,o[12]}, liop=IMM, iv.
  - 101: SM. brad=[11:10], arad=[9:8], op={0,o[12]}, liop=IMM, iv, dmwe=1, we=0.
  - 011/110/111: decoded as NOP with illegal=1 for the cycle out_valid first rises on it.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv && !hazard && !halted && rst_n.
  - Accept when in_valid && in_ready: output register loads the decoded fields and out_valid=1, one-cycle latency.
  - When adv && !accept: out_valid goes 0 (bubble) and the fields hold their last values.
  - When !adv: the output register holds all fields stable.
- Load shadow:
  - LD_LAT-entry shift of {ld, wad}, advanced on adv.
  - Entry 0 receives {1, wad} when an accepted instruction has dms=1; otherwise it receives {0, x}.
- Hazard:
  - Raised when any used source of the candidate (ins) matches the wad of a valid shadow entry.
  - Used sources: arad for CAL-imm and LM-imm; brad for LIL/LIH; arad and brad for CAL-reg, LM-reg and SM.
  - Hazard inserts bubbles until the matching entry shifts out. Exactly LD_LAT bubbles follow a back-to-back dependent load, provided out_ready stays high.
- HALT:
  - On acceptance, h=1 is output and halted is set on the same edge.
  - in_ready then stays 0 until reset.
  - The HALT output itself still completes its handshake.
- Simultaneous in_valid with hazard: no acceptance, and the instruction must be held by fetch.

Decomposition:
- pu package (pu.vh successor, as a SystemVerilog package) holds:
  - liop enum (THU, IMM, LIL, LIH);
  - opcode constants for ins[15:13];
  - op constants ADD=0, SUB=1, TRU=2;
  - field-position localparams.
- Sub-module pu_dec_comb: purely combinational ins -> fields, plus source-use flags (ua, ub) and an illegal flag.
- pu_dec_stage adds the registers, shadow logic and handshake around it.

Test Plan:
- Reset then 16'h0607 with out_ready=1:
  - next cycle out_valid=1, we=1, wad=1, arad=2, brad=3, op=0, liop=THU.
- LM-imm 16'h8405 then 16'h0904, LD_LAT=1:
  - first outputs dms=1, wad=1, arad=0, iv=5, liop=IMM;
  - then exactly one bubble (in_ready=0 one cycle);
  - then arad=1, brad=0.
- Same sequence with 16'h4CAB second (no dependency):
  - no bubble; liop=LIL, brad=0, iv=8'hAB.
  - With LD_LAT=3 and 16'h0904 second: three bubbles.
- SM 16'hA402:
  - dmwe=1, we=0, brad=1, arad=0, iv=2.
  - Hold out_ready=0 for 3 cycles: fields stable and in_ready=0.
- 16'h0001 then 16'h0607:
  - h=1 and halted=1;
  - in_ready stays 0 and the second word is never accepted;
  - rst_n pulse clears halted and 16'h0607 is accepted.
- 16'h6000:
  - illegal=1 for one cycle, we=0, dmwe=0, dms=0.
